spi_dual_lane_link: RTL and testbench

Two-lane SPI link containing a transmit (master) side and a receive (slave) side on one clock.
- Master side: continuously serialises a 16-bit word over SCK/CS and two data lanes. Lane 1 carries bits [15:8] and lane 2 carries bits [7:0], both MSB first.
- Slave side: deserialises SCK/CS/two lanes back into a 16-bit word.
- Master outputs and slave inputs are separate ports. The integrator (or bench) loops them back.

---
 rtl/spi_link_pkg.sv | 19 +
 rtl/spi_dual_lane_rx.sv | 61 ++++++
 rtl/spi_dual_lane_link.sv | 134 +++++++++++++
 tb/tb_spi_dual_lane_link.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_link_pkg.sv
// Shared constants and types for the dual-lane SPI link.
package spi_link_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int LANE_W_DEF = DATA_W_DEF / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SETUP = 2'd2,
    SHIFT = 2'd3
  } mst_state_e;

  // Bits carried by each lane for a given word width.
  function automatic int lane_w(input int dw);
    return dw / 2;
  endfunction

endpackage

// File: rtl/spi_dual_lane_rx.sv
// Slave deserialiser: rebuilds a word from SCK/CS and two data lanes.
module spi_dual_lane_rx
  import spi_link_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs,
  input  logic              rx_ch1,
  input  logic              rx_ch2,
  output logic [DATA_W-1:0] getdata,
  output logic              valid
);

  localparam int LANE = lane_w(DATA_W);
  localparam int CW   = $clog2(LANE + 1);

  logic            sck_d, cs_d;
  logic [CW-1:0]   cnt;
  logic [LANE-1:0] up, lo;
  logic            cs_fall, cs_rise, sck_rise;

  assign cs_fall  = cs_d & ~cs;
  assign cs_rise  = ~cs_d & cs;
  assign sck_rise = ~sck_d & sck & ~cs;

  // Edge detect, shift-in on SCK rise, publish the word on CS rise if complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_d   <= 1'b0;
      cs_d    <= 1'b1;
      cnt     <= '0;
      up      <= '0;
      lo      <= '0;
      getdata <= '0;
      valid   <= 1'b0;
    end else begin
      sck_d <= sck;
      cs_d  <= cs;
      valid <= 1'b0;
      // A new frame wins over an SCK edge landing in the same cycle.
      if (cs_fall) begin
        cnt <= '0;
        up  <= '0;
        lo  <= '0;
      end else if (sck_rise) begin
        up <= LANE'({up, rx_ch1});
        lo <= LANE'({lo, rx_ch2});
        if (cnt != CW'(LANE)) cnt <= cnt + CW'(1);
      end
      // Short frames are dropped silently.
      if (cs_rise && cnt == CW'(LANE)) begin
        getdata <= {up, lo};
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_dual_lane_link.sv
// Dual-lane SPI link: free-running master serialiser plus slave deserialiser.
module spi_dual_lane_link
  import spi_link_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int HALF   = 2,
  parameter int GAP    = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] i_send_data,
  output logic              o_sck,
  output logic              o_cs,
  output logic              o_tx_ch1,
  output logic              o_tx_ch2,
  input  logic              i_sck,
  input  logic              i_cs,
  input  logic              i_rx_ch1,
  input  logic              i_rx_ch2,
  output logic [DATA_W-1:0] o_getdata,
  output logic              o_valid
);

  localparam int LANE = lane_w(DATA_W);
  localparam int CMAX = (GAP > HALF) ? GAP : HALF;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(LANE + 1);

  mst_state_e      state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [BW-1:0]   bitn, bitn_n;
  logic [LANE-1:0] hi, hi_n, lo, lo_n;
  logic            sck_q, sck_n, cs_q, cs_n;

  // Outputs come straight from flops; lane data is the shift-register MSB.
  assign o_sck    = sck_q;
  assign o_cs     = cs_q;
  assign o_tx_ch1 = hi[LANE-1];
  assign o_tx_ch2 = lo[LANE-1];

  // Master state and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      cnt   <= CW'(GAP);
      bitn  <= '0;
      hi    <= '0;
      lo    <= '0;
      sck_q <= 1'b0;
      cs_q  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      hi    <= hi_n;
      lo    <= lo_n;
      sck_q <= sck_n;
      cs_q  <= cs_n;
    end
  end

  // Next-state logic; register values are set for the state being entered,
  // so CS is already low and the first bits are on the lanes during LOAD.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bitn_n  = bitn;
    hi_n    = hi;
    lo_n    = lo;
    sck_n   = sck_q;
    cs_n    = cs_q;
    case (state)
      IDLE: begin
        cs_n  = 1'b1;
        sck_n = 1'b0;
        if (cnt == CW'(1)) begin
          state_n = LOAD;
          hi_n    = i_send_data[DATA_W-1:LANE];
          lo_n    = i_send_data[LANE-1:0];
          cs_n    = 1'b0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      LOAD: begin
        state_n = SETUP;
        cnt_n   = CW'(HALF);
      end
      SETUP: begin
        if (cnt == CW'(1)) begin
          state_n = SHIFT;
          cnt_n   = CW'(HALF);
          bitn_n  = '0;
          sck_n   = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      SHIFT: begin
        if (cnt == CW'(1)) begin
          cnt_n = CW'(HALF);
          if (sck_q) begin
            // Falling edge: advance both lanes to the next bit.
            sck_n = 1'b0;
            hi_n  = hi << 1;
            lo_n  = lo << 1;
          end else if (bitn == BW'(LANE - 1)) begin
            state_n = IDLE;
            cnt_n   = CW'(GAP);
            cs_n    = 1'b1;
          end else begin
            bitn_n = bitn + BW'(1);
            sck_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  spi_dual_lane_rx #(.DATA_W(DATA_W)) u_rx (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .sck     (i_sck),
    .cs      (i_cs),
    .rx_ch1  (i_rx_ch1),
    .rx_ch2  (i_rx_ch2),
    .getdata (o_getdata),
    .valid   (o_valid)
  );

endmodule

// File: tb/tb_spi_dual_lane_link.sv
// Bench for spi_dual_lane_link: loopback frames plus directly driven slave.
module tb_spi_dual_lane_link;

  localparam int DW   = 16;
  localparam int HALF = 2;
  localparam int GAP  = 4;
  localparam int LANE = DW / 2;
  localparam int P    = 1 + HALF + DW * HALF + GAP;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [DW-1:0] i_send_data = '0;
  logic          o_sck, o_cs, o_tx_ch1, o_tx_ch2, o_valid;
  logic [DW-1:0] o_getdata;
  logic          i_sck, i_cs, i_rx_ch1, i_rx_ch2;
  logic          lb = 1'b1;
  logic          drv_sck = 1'b0, drv_cs = 1'b1, drv_ch1 = 1'b0, drv_ch2 = 1'b0;

  assign i_sck    = lb ? o_sck    : drv_sck;
  assign i_cs     = lb ? o_cs     : drv_cs;
  assign i_rx_ch1 = lb ? o_tx_ch1 : drv_ch1;
  assign i_rx_ch2 = lb ? o_tx_ch2 : drv_ch2;

  spi_dual_lane_link #(.DATA_W(DW), .HALF(HALF), .GAP(GAP)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .i_send_data(i_send_data),
    .o_sck(o_sck), .o_cs(o_cs), .o_tx_ch1(o_tx_ch1), .o_tx_ch2(o_tx_ch2),
    .i_sck(i_sck), .i_cs(i_cs), .i_rx_ch1(i_rx_ch1), .i_rx_ch2(i_rx_ch2),
    .o_getdata(o_getdata), .o_valid(o_valid)
  );

  always #5 sys_clk = ~sys_clk;

  int            passed = 0, total = 0;
  int            cyc = 0;
  logic [DW-1:0] data_log [0:1023];
  logic [DW-1:0] exp_last;

  // Observation of the DUT's master and slave outputs
  logic          prev_sck = 1'b0, prev_cs = 1'b1;
  logic [7:0]    w1, w2;
  int            rises = 0, hi_run = 0, sck_bad = 0;
  int            ev_cyc[$];
  logic [DW-1:0] ev_dat[$];
  int            win_rises[$];
  logic [DW-1:0] win_dat[$];
  int            gap_q[$];

  task automatic clear_mon();
    ev_cyc.delete(); ev_dat.delete(); win_rises.delete(); win_dat.delete(); gap_q.delete();
    rises = 0; hi_run = 0; sck_bad = 0; w1 = '0; w2 = '0;
    prev_sck = o_sck; prev_cs = o_cs;
  endtask

  // One clock cycle: log the input word, observe at negedge, advance past posedge.
  task automatic tick();
    if (cyc < 1024) data_log[cyc] = i_send_data;
    @(negedge sys_clk);
    if (o_sck && o_cs) sck_bad++;
    if (!o_cs && prev_cs) begin
      if (hi_run > 0) gap_q.push_back(hi_run);
      hi_run = 0; rises = 0; w1 = '0; w2 = '0;
    end
    if (!o_cs && o_sck && !prev_sck) begin
      w1 = {w1[6:0], o_tx_ch1};
      w2 = {w2[6:0], o_tx_ch2};
      rises++;
    end
    if (o_cs && !prev_cs) begin
      win_rises.push_back(rises);
      win_dat.push_back({w1, w2});
    end
    if (o_cs) hi_run++;
    if (o_valid) begin
      ev_cyc.push_back(cyc);
      ev_dat.push_back(o_getdata);
    end
    prev_cs = o_cs; prev_sck = o_sck;
    @(posedge sys_clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick(); tick();
  endtask

  task automatic release_reset();
    sys_rst = 1'b0;
    clear_mon();
    cyc = 0;
  endtask

  // Drive the slave directly: optional simultaneous CS-fall/SCK-rise, then np bits.
  task automatic dframe(input logic [DW-1:0] w, input int np, input bit sim);
    drv_cs = 1'b1; drv_sck = 1'b0;
    tick(); tick();
    drv_cs = 1'b0;
    if (sim) drv_sck = 1'b1;
    tick();
    drv_sck = 1'b0;
    tick();
    for (int i = 0; i < np; i++) begin
      drv_ch1 = w[15-i]; drv_ch2 = w[7-i];
      tick(); tick();
      drv_sck = 1'b1;
      tick(); tick();
      drv_sck = 1'b0;
    end
    tick();
    drv_cs = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_cs !== 1'b1) $display("FAIL reset_cs: got %b want 1", o_cs); else passed++;
    total++; if (o_sck !== 1'b0) $display("FAIL reset_sck: got %b want 0", o_sck); else passed++;
    total++; if (o_tx_ch1 !== 1'b0) $display("FAIL reset_ch1: got %b want 0", o_tx_ch1); else passed++;
    total++; if (o_tx_ch2 !== 1'b0) $display("FAIL reset_ch2: got %b want 0", o_tx_ch2); else passed++;
    total++; if (o_getdata !== 16'h0) $display("FAIL reset_getdata: got %h want 0000", o_getdata); else passed++;
    total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else passed++;
    release_reset();
  endtask

  task automatic test_loopback();
    logic [DW-1:0] wd;
    i_send_data = 16'h8001;
    while (cyc < 20) tick();
    i_send_data = 16'hA041;   // lands mid-frame; must not disturb frame 0
    while (cyc < 42) tick();
    wd = (win_dat.size() > 0) ? win_dat[0] : 'x;
    total++; if (win_dat.size() != 1) $display("FAIL lb_windows: got %0d want 1", win_dat.size()); else passed++;
    total++; if (wd[15:8] !== 8'h80) $display("FAIL lb_ch1_bits: got %h want 80", wd[15:8]); else passed++;
    total++; if (wd[7:0] !== 8'h01) $display("FAIL lb_ch2_bits: got %h want 01", wd[7:0]); else passed++;
    total++; if (win_rises.size() == 0 || win_rises[0] != LANE)
      $display("FAIL lb_rises: got %0d want %0d", (win_rises.size() > 0) ? win_rises[0] : -1, LANE); else passed++;
    total++; if (ev_cyc.size() != 1) $display("FAIL lb_valid_count: got %0d want 1", ev_cyc.size()); else passed++;
    total++; if (ev_cyc.size() == 0 || ev_cyc[0] != P + 1)
      $display("FAIL lb_valid_cycle: got %0d want %0d", (ev_cyc.size() > 0) ? ev_cyc[0] : -1, P + 1); else passed++;
    total++; if (ev_dat.size() == 0 || ev_dat[0] !== 16'h8001)
      $display("FAIL lb_getdata: got %h want 8001", (ev_dat.size() > 0) ? ev_dat[0] : 16'hxxxx); else passed++;
  endtask

  task automatic test_mid_frame_change();
    while (cyc < 2 * P + 3) tick();
    total++; if (ev_dat.size() != 2) $display("FAIL mid_valid_count: got %0d want 2", ev_dat.size()); else passed++;
    total++; if (ev_dat.size() < 2 || ev_dat[1] !== 16'hA041)
      $display("FAIL mid_second_word: got %h want a041", (ev_dat.size() > 1) ? ev_dat[1] : 16'hxxxx); else passed++;
    total++; if (ev_cyc.size() < 2 || ev_cyc[1] != 2 * P + 1)
      $display("FAIL mid_second_cycle: got %0d want %0d", (ev_cyc.size() > 1) ? ev_cyc[1] : -1, 2 * P + 1); else passed++;
  endtask

  // Random input churn; frame k carries whatever was on i_send_data at its start cycle.
  task automatic test_back_to_back();
    int n_ev, n_win, n_fall;
    while (cyc < 10 * P + 3) begin
      if ($urandom_range(2) == 0) i_send_data = 16'($urandom);
      tick();
    end
    n_ev = 0; n_win = 0; n_fall = 0;
    while ((n_ev + 1) * P + 1 < cyc) n_ev++;
    while ((n_win + 1) * P < cyc) n_win++;
    while (GAP + n_fall * P < cyc) n_fall++;
    total++; if (ev_cyc.size() != n_ev) $display("FAIL b2b_valid_count: got %0d want %0d", ev_cyc.size(), n_ev); else passed++;
    for (int k = 0; k < ev_cyc.size() && k < n_ev; k++) begin
      total++; if (ev_cyc[k] != (k + 1) * P + 1)
        $display("FAIL b2b_valid_cycle[%0d]: got %0d want %0d", k, ev_cyc[k], (k + 1) * P + 1); else passed++;
      total++; if (ev_dat[k] !== data_log[GAP - 1 + k * P])
        $display("FAIL b2b_word[%0d]: got %h want %h", k, ev_dat[k], data_log[GAP - 1 + k * P]); else passed++;
    end
    total++; if (win_dat.size() != n_win) $display("FAIL b2b_windows: got %0d want %0d", win_dat.size(), n_win); else passed++;
    for (int k = 0; k < win_dat.size() && k < n_win; k++) begin
      total++; if (win_rises[k] != LANE) $display("FAIL b2b_rises[%0d]: got %0d want %0d", k, win_rises[k], LANE); else passed++;
      total++; if (win_dat[k] !== data_log[GAP - 1 + k * P])
        $display("FAIL b2b_lane_bits[%0d]: got %h want %h", k, win_dat[k], data_log[GAP - 1 + k * P]); else passed++;
    end
    total++; if (gap_q.size() != n_fall) $display("FAIL b2b_gap_count: got %0d want %0d", gap_q.size(), n_fall); else passed++;
    foreach (gap_q[k]) begin
      total++; if (gap_q[k] != GAP) $display("FAIL b2b_gap[%0d]: got %0d want %0d", k, gap_q[k], GAP); else passed++;
    end
    total++; if (sck_bad != 0) $display("FAIL b2b_sck_while_cs_high: got %0d want 0", sck_bad); else passed++;
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    release_reset();
    i_send_data = 16'($urandom);
    while (cyc < 20) tick();
    sys_rst = 1'b1;
    tick();
    total++; if (o_cs !== 1'b1) $display("FAIL rst_mid_cs: got %b want 1", o_cs); else passed++;
    total++; if (o_sck !== 1'b0) $display("FAIL rst_mid_sck: got %b want 0", o_sck); else passed++;
    total++; if (ev_cyc.size() != 0) $display("FAIL rst_mid_no_valid: got %0d want 0", ev_cyc.size()); else passed++;
    release_reset();
    i_send_data = 16'($urandom);
    while (cyc < P + 3) tick();
    exp_last = data_log[GAP - 1];
    total++; if (ev_cyc.size() != 1) $display("FAIL rst_mid_valid_count: got %0d want 1", ev_cyc.size()); else passed++;
    total++; if (ev_cyc.size() == 0 || ev_cyc[0] != P + 1)
      $display("FAIL rst_mid_valid_cycle: got %0d want %0d", (ev_cyc.size() > 0) ? ev_cyc[0] : -1, P + 1); else passed++;
    total++; if (o_getdata !== exp_last) $display("FAIL rst_mid_word: got %h want %h", o_getdata, exp_last); else passed++;
  endtask

  task automatic test_direct_slave();
    logic [DW-1:0] w;
    drv_cs = 1'b1; drv_sck = 1'b0;
    lb = 1'b0;
    tick(); tick();
    clear_mon();
    dframe(16'($urandom), 5, 1'b0);
    total++; if (ev_cyc.size() != 0) $display("FAIL short_no_valid: got %0d want 0", ev_cyc.size()); else passed++;
    total++; if (o_getdata !== exp_last) $display("FAIL short_getdata: got %h want %h", o_getdata, exp_last); else passed++;
    // Coincident CS fall / SCK rise is not sampled, so 7 more bits leave the frame short.
    dframe(16'($urandom), 7, 1'b1);
    total++; if (ev_cyc.size() != 0) $display("FAIL simul_no_valid: got %0d want 0", ev_cyc.size()); else passed++;
    total++; if (o_getdata !== exp_last) $display("FAIL simul_getdata: got %h want %h", o_getdata, exp_last); else passed++;
    w = 16'($urandom);
    dframe(w, 8, 1'b0);
    total++; if (ev_cyc.size() != 1) $display("FAIL direct_valid_count: got %0d want 1", ev_cyc.size()); else passed++;
    total++; if (o_getdata !== w) $display("FAIL direct_word: got %h want %h", o_getdata, w); else passed++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_mid_frame_change();
    test_back_to_back();
    test_reset_mid_shift();
    test_direct_slave();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
